mips_multicycle_control: RTL

Main control FSM for the multicycle MIPS datapath. It is the producer side of the `ALUOp` interface: it sequences fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, plus the 2-bit `ALUOp` that the ALU control decoder combines with `funct` to form `ALUCtl`. It supports lw, sw, R-type, beq, addi and j, with a ready handshake toward unified instruction/data memory.

---
 rtl/mips_multicycle_control_if.sv | 36 +++
 rtl/mips_multicycle_control.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control_if.sv
// Signal bundle between the multicycle control FSM and the MIPS datapath.
// The control FSM uses the master side; the datapath uses the slave side.
interface mips_multicycle_control_if;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       IorD;
    logic       ALUSrcA;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [1:0] ALUOp;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       PCWrite;
    logic       Branch;
    logic       PCEn;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op, Zero, MemReady,
        output IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp,
               IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn,
               IllegalOp, State
    );

    modport slave (
        output Op, Zero, MemReady,
        input  IorD, ALUSrcA, RegDst, MemtoReg, ALUSrcB, PCSrc, ALUOp,
               IRWrite, MemWrite, RegWrite, PCWrite, Branch, PCEn,
               IllegalOp, State
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Moore outputs decoded from the current state, with a ready handshake toward memory.
module mips_multicycle_control (
    input  logic                              clk,
    input  logic                              reset_n,
    mips_multicycle_control_if.master         bus
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    state_t     out_state_s;

    logic       iord_s;
    logic       alusrca_s;
    logic       regdst_s;
    logic       memtoreg_s;
    logic [1:0] alusrcb_s;
    logic [1:0] pcsrc_s;
    logic [1:0] aluop_s;
    logic       irwrite_s;
    logic       memwrite_s;
    logic       regwrite_s;
    logic       pcwrite_s;
    logic       branch_s;
    logic       illegalop_s;

    // Dispatch target chosen in Decode from the opcode field.
    function automatic state_t decode_dispatch(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECUTE;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; memory states hold until MemReady.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:    state_next_s = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE:   state_next_s = decode_dispatch(bus.Op);
            S_MEMADR: begin
                if (bus.Op == OP_LW) begin
                    state_next_s = S_MEMREAD;
                end else if (bus.Op == OP_SW) begin
                    state_next_s = S_MEMWRITE;
                end else begin
                    state_next_s = S_ILLEGAL;
                end
            end
            S_MEMREAD:  state_next_s = bus.MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next_s = S_FETCH;
            S_MEMWRITE: state_next_s = bus.MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTE:  state_next_s = S_ALUWB;
            S_ALUWB:    state_next_s = S_FETCH;
            S_BRANCH:   state_next_s = S_FETCH;
            S_ADDIEX:   state_next_s = S_ADDIWB;
            S_ADDIWB:   state_next_s = S_FETCH;
            S_JUMP:     state_next_s = S_FETCH;
            S_ILLEGAL:  state_next_s = S_FETCH;
            default:    state_next_s = S_FETCH;
        endcase
    end

    // Moore output decode; during reset the selects show their Fetch values.
    always_comb begin
        iord_s      = 1'b0;
        alusrca_s   = 1'b0;
        regdst_s    = 1'b0;
        memtoreg_s  = 1'b0;
        alusrcb_s   = 2'b00;
        pcsrc_s     = 2'b00;
        aluop_s     = 2'b00;
        irwrite_s   = 1'b0;
        memwrite_s  = 1'b0;
        regwrite_s  = 1'b0;
        pcwrite_s   = 1'b0;
        branch_s    = 1'b0;
        illegalop_s = 1'b0;
        out_state_s = reset_n ? state_r : S_FETCH;
        case (out_state_s)
            S_FETCH: begin
                alusrcb_s = 2'b01;
                irwrite_s = bus.MemReady;
                pcwrite_s = bus.MemReady;
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_MEMREAD: begin
                iord_s = 1'b1;
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
            end
            S_MEMWRITE: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTE: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
                branch_s  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
            end
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
            end
            S_ILLEGAL: begin
                illegalop_s = 1'b1;
            end
            default: begin
                alusrcb_s = 2'b00;
            end
        endcase
    end

    assign bus.IorD      = iord_s;
    assign bus.ALUSrcA   = alusrca_s;
    assign bus.RegDst    = regdst_s;
    assign bus.MemtoReg  = memtoreg_s;
    assign bus.ALUSrcB   = alusrcb_s;
    assign bus.PCSrc     = pcsrc_s;
    assign bus.ALUOp     = aluop_s;
    // Enables are gated by reset so an aborted instruction cannot write anything.
    assign bus.IRWrite   = irwrite_s   & reset_n;
    assign bus.MemWrite  = memwrite_s  & reset_n;
    assign bus.RegWrite  = regwrite_s  & reset_n;
    assign bus.PCWrite   = pcwrite_s   & reset_n;
    assign bus.Branch    = branch_s    & reset_n;
    assign bus.IllegalOp = illegalop_s & reset_n;
    assign bus.PCEn      = (pcwrite_s | (branch_s & bus.Zero)) & reset_n;
    assign bus.State     = state_r;

endmodule
